// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Multiplexes a DIGITS-wide BCD value onto one shared segment decoder and
//   a bank of one-hot digit enables. Each digit gets a BLANK gap of GAP clocks
//   (all enables off, decoder input already switched) followed by a SHOW slot
//   of SCAN_DIV clocks. The displayed value is double buffered: a load lands
//   in a pending register and is committed to the active register only at the
//   frame boundary, so a frame never mixes old and new digits.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When defined, a digit above digit 0 stays dark in its SHOW slot if it
//     and every higher digit are zero. Timing, num and frame_start unchanged.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | one cycle after reset release; next edge starts frame at digit 0
//   BLANK | all digit enables off, num already shows the upcoming digit
//   SHOW  | enable of the current digit on, num shows its nibble

module seg_scan_controller #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000,
   parameter int GAP      = 4,
   parameter int CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   output logic                  ready,
   output logic [3:0]            num,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_start
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] SHOW_TC = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [4*DIGITS-1:0]    active_q, active_d;
   logic [4*DIGITS-1:0]    pend_q, pend_d;
   logic                   pend_vld_q, pend_vld_d;
   logic                   ready_q, ready_d;
   logic [3:0]             num_q, num_d;
   logic [DIGITS-1:0]      dig_sel_q, dig_sel_d;
   logic                   frame_start_q, frame_start_d;
   logic                   enter_frame;
   logic                   lz_lit;

   // Phase sequencing: IDLE -> BLANK(GAP) -> SHOW(SCAN_DIV) -> next digit BLANK
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      enter_frame = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d     = ST_BLANK;
            idx_d       = '0;
            cnt_d       = '0;
            enter_frame = 1'b1;
         end
         ST_BLANK: begin
            if (cnt_q == GAP_TC) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHOW: begin
            if (cnt_q == SHOW_TC) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               if (idx_q == LAST_IX) begin
                  idx_d       = '0;
                  enter_frame = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Double buffer: accept into pending while free, commit at frame boundary.
   // Commit and accept are exclusive since accept needs pending to be empty.
   always_comb begin
      active_d   = active_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (enter_frame && pend_vld_q) begin
         active_d   = pend_q;
         pend_vld_d = 1'b0;
      end else if (load && !pend_vld_q) begin
         pend_d     = din;
         pend_vld_d = 1'b1;
      end
      ready_d = !pend_vld_d;
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Digit stays lit if it is digit 0 or any nibble at or above it is nonzero
   always_comb begin
      lz_lit = (idx_d == '0);
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(idx_d) && active_d[4*i +: 4] != 4'h0) begin
            lz_lit = 1'b1;
         end
      end
   end
`else
   assign lz_lit = 1'b1;
`endif

   // Output decode from next state so that outputs are registered with it;
   // num uses the post-commit value so a new frame starts with new digits
   always_comb begin
      num_d         = active_d[4*idx_d +: 4];
      dig_sel_d     = '0;
      frame_start_d = enter_frame;
      if (state_d == ST_SHOW && lz_lit) begin
         dig_sel_d = DIGITS'(1) << idx_d;
      end
   end

   // State, buffers and outputs; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         active_q      <= '0;
         pend_q        <= '0;
         pend_vld_q    <= 1'b0;
         ready_q       <= 1'b1;
         num_q         <= 4'h0;
         dig_sel_q     <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         active_q      <= active_d;
         pend_q        <= pend_d;
         pend_vld_q    <= pend_vld_d;
         ready_q       <= ready_d;
         num_q         <= num_d;
         dig_sel_q     <= dig_sel_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign ready       = ready_q;
   assign num         = num_q;
   assign dig_sel     = dig_sel_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller (DIGITS=4, SCAN_DIV=4, GAP=2).
// The reference model derives every cycle's outputs from the cycle count since
// reset release: position in frame, digit = pos / slot, lit = offset >= GAP.
module tb_seg_scan_controller;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam int GAP      = 2;
   localparam int CNT_W    = 8;
   localparam int SLOT     = GAP + SCAN_DIV;
   localparam int FRAME    = DIGITS * SLOT;

   logic                clk;
   logic                rst;
   logic                load;
   logic [4*DIGITS-1:0] din;
   logic                ready;
   logic [3:0]          num;
   logic [DIGITS-1:0]   dig_sel;
   logic                frame_start;

   seg_scan_controller #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .GAP      (GAP),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .din         (din),
      .ready       (ready),
      .num         (num),
      .dig_sel     (dig_sel),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DIGITS-1:0] dig;
      logic [3:0]        nib;
      logic              rdy;
      logic              fs;
   } exp_t;

   exp_t exp_q[$];

   int passed = 0;
   int total  = 0;

   // model state
   int                  m_n    = -1;
   logic [4*DIGITS-1:0] m_act  = '0;
   logic [4*DIGITS-1:0] m_pend = '0;
   bit                  m_pvld = 1'b0;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   // Reference model: one expected output set per clock edge
   always @(posedge clk) begin
      exp_t e;
      int   pos, dg;
      bit   lit;
      if (!rst) begin
         m_n    = -1;
         m_act  = '0;
         m_pvld = 1'b0;
         e.dig = '0; e.nib = 4'h0; e.rdy = 1'b1; e.fs = 1'b0;
      end else begin
         m_n++;
         pos = m_n % FRAME;
         if (pos == 0 && m_pvld) begin
            m_act  = m_pend;
            m_pvld = 1'b0;
         end else if (load && !m_pvld) begin
            m_pend = din;
            m_pvld = 1'b1;
         end
         dg  = pos / SLOT;
         lit = (pos % SLOT) >= GAP;
`ifdef LEADING_ZERO_BLANK_EN
         lit = lit && (dg == 0 || (m_act >> (4*dg)) != 0);
`endif
         e.dig = lit ? DIGITS'(1 << dg) : '0;
         e.nib = m_act[4*dg +: 4];
         e.rdy = !m_pvld;
         e.fs  = (pos == 0);
      end
      exp_q.push_back(e);
   end

   // Monitor: compares each presented output set against the scoreboard
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
         total++;
         $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
      end else begin
         e = exp_q.pop_front();
         check("dig_sel",     8'(dig_sel),     8'(e.dig));
         check("num",         8'(num),         8'(e.nib));
         check("ready",       8'(ready),       8'(e.rdy));
         check("frame_start", 8'(frame_start), 8'(e.fs));
      end
   end

   task automatic do_load(input logic [4*DIGITS-1:0] v);
      load = 1'b1;
      din  = v;
      @(negedge clk);
      load = 1'b0;
      din  = $urandom;
   endtask

   // Bounded wait until the model says the current cycle is frame position p
   task automatic wait_pos(input int p);
      int budget = 4 * FRAME;
      while (!(m_n >= 0 && (m_n % FRAME) == p) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         total++;
         $display("FAIL wait_pos: got timeout, required position %0d", p);
      end
   endtask

   initial begin
      rst  = 1'b0;
      load = 1'b0;
      din  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // first value, committed at the second frame boundary
      do_load(16'h1234);
      wait_pos(0);
      @(negedge clk);
      wait_pos(8);
      // mid-frame load, then a load while busy that must be ignored
      do_load(16'h5678);
      wait_pos(12);
      do_load(16'h9999);
      repeat (2 * FRAME) @(negedge clk);

      // reset in digit 2 SHOW with a pending value
      wait_pos(3);
      do_load(16'hABCD);
      wait_pos(15);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (FRAME + 4) @(negedge clk);

      // leading-zero patterns and non-BCD nibbles
      do_load(16'h0070);
      repeat (2 * FRAME) @(negedge clk);
      do_load(16'h0000);
      repeat (2 * FRAME) @(negedge clk);
      do_load(16'hF00E);
      repeat (2 * FRAME) @(negedge clk);

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) rst = 1'b0;
         else rst = 1'b1;
         load = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 2))
            0:       din = $urandom;
            1:       din = 16'($urandom) & 16'h00FF;
            default: din = 16'($urandom) & 16'h0F0F;
         endcase
         @(negedge clk);
      end
      rst  = 1'b1;
      load = 1'b0;
      repeat (3) @(negedge clk);

      total++;
      if (exp_q.size() <= 1) passed++;
      else $display("FAIL scoreboard_drain: got %0d entries left, required at most 1", exp_q.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
